// File: rtl/demux1t2_32_stream.sv
// demux1t2_32_stream: 32-bit 1-to-2 stream demultiplexer.
// One valid/ready input is steered by in_sel into one of two independent
// 2-entry FIFOs, each drained by its own valid/ready output channel. A full
// target FIFO back-pressures the input, and a pop does not free a slot in
// the same cycle (no fall-through when full).
// Optional feature: define DEMUX_STATS_EN to add o0_cnt/o1_cnt, 16-bit
// wrapping counts of words accepted into each channel.
module demux1t2_32_stream #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sel,
  output logic          o0_valid,
  input  logic          o0_ready,
  output logic [DW-1:0] o0_data,
  output logic          o1_valid,
  input  logic          o1_ready,
  output logic [DW-1:0] o1_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]   o0_cnt,
  output logic [15:0]   o1_cnt
`endif
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  // Per-channel FIFO state, indexed by channel number.
  logic [DW-1:0] mem_q  [2][2];
  logic          wptr_q [2];
  logic          rptr_q [2];
  logic [1:0]    cnt_q  [2];
  logic [1:0]    cnt_d  [2];
  logic [DW-1:0] hold_q [2];  // last value shown on oN_data
  logic [DW-1:0] head   [2];

  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_valid;
  logic [1:0] out_ready;

  assign out_ready = {o1_ready, o0_ready};

  // Readiness depends only on the selected FIFO's registered count, never
  // on the consumers' ready inputs.
  assign in_ready = rst_n & (cnt_q[in_sel] != FULL);

  // Handshakes, next counts and the visible head word per channel.
  always_comb begin
    push      = '0;
    pop       = '0;
    out_valid = '0;
    for (int n = 0; n < 2; n++) begin
      out_valid[n] = (cnt_q[n] != 2'd0);
      push[n]      = in_valid & in_ready & (in_sel == n[0]);
      pop[n]       = out_valid[n] & out_ready[n];
      // While empty, present the last shown word rather than a stale slot.
      head[n]      = out_valid[n] ? mem_q[n][rptr_q[n]] : hold_q[n];
      unique case ({push[n], pop[n]})
        2'b10:   cnt_d[n] = cnt_q[n] + 2'd1;
        2'b01:   cnt_d[n] = cnt_q[n] - 2'd1;
        default: cnt_d[n] = cnt_q[n];
      endcase
    end
  end

  assign o0_valid = out_valid[0];
  assign o1_valid = out_valid[1];
  assign o0_data  = head[0];
  assign o1_data  = head[1];

  // FIFO storage, pointers, counts and output hold registers.
  // NOTE: the storage is reset too; with only two words per channel this is
  // cheap and guarantees oN_data reads 0 out of reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        mem_q[n][0] <= '0;
        mem_q[n][1] <= '0;
        wptr_q[n]   <= 1'b0;
        rptr_q[n]   <= 1'b0;
        cnt_q[n]    <= 2'd0;
        hold_q[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) begin
          mem_q[n][wptr_q[n]] <= in_data;
          wptr_q[n]           <= ~wptr_q[n];
        end
        if (pop[n]) begin
          rptr_q[n] <= ~rptr_q[n];
        end
        cnt_q[n]  <= cnt_d[n];
        hold_q[n] <= head[n];
      end
    end
  end

`ifdef DEMUX_STATS_EN
  logic [15:0] stat_q [2];

  // Per-channel push counters, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q[0] <= 16'h0;
      stat_q[1] <= 16'h0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) stat_q[n] <= stat_q[n] + 16'd1;
      end
    end
  end

  assign o0_cnt = stat_q[0];
  assign o1_cnt = stat_q[1];
`endif

endmodule

// File: tb/tb_demux1t2_32_stream.sv
// Testbench for demux1t2_32_stream: directed vectors, with expected words
// queued per channel at issue time and a negedge monitor comparing every
// output handshake against the queue head.
module tb_demux1t2_32_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        o0_valid, o0_ready;
  logic [31:0] o0_data;
  logic        o1_valid, o1_ready;
  logic [31:0] o1_data;
`ifdef DEMUX_STATS_EN
  logic [15:0] o0_cnt, o1_cnt;
`endif

  demux1t2_32_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .o0_valid (o0_valid),
    .o0_ready (o0_ready),
    .o0_data  (o0_data),
    .o1_valid (o1_valid),
    .o1_ready (o1_ready),
    .o1_data  (o1_data)
`ifdef DEMUX_STATS_EN
    ,
    .o0_cnt   (o0_cnt),
    .o1_cnt   (o1_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a word (called 1 ns after an edge); waits for in_ready, records
  // the expectation, and returns 1 ns after the accepting edge with
  // in_valid still high so back-to-back calls stream one word per cycle.
  task automatic send(input logic [31:0] d, input logic s);
    int budget = 50;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    #1;
    while (!in_ready && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      if (s) exp1.push_back(d);
      else   exp0.push_back(d);
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset asserted between edges; queued words are discarded.
  task automatic apply_reset;
    #2;
    rst_n = 1'b0;
    exp0.delete();
    exp1.delete();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every output handshake must match its channel's queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o0_valid && o0_ready) begin
        if (exp0.size() == 0) check("ch0_extra_word", o0_data, 32'hFFFF_FFFF ^ o0_data);
        else                  check("ch0_order", o0_data, exp0.pop_front());
      end
      if (o1_valid && o1_ready) begin
        if (exp1.size() == 0) check("ch1_extra_word", o1_data, 32'hFFFF_FFFF ^ o1_data);
        else                  check("ch1_order", o1_data, exp1.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_sel   = 1'b0;
    o0_ready = 1'b0;
    o1_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_o0_valid", 32'(o0_valid), 32'd0);
    check("rst_o1_valid", 32'(o1_valid), 32'd0);
    check("rst_o0_data", o0_data, 32'h0);
    check("rst_o1_data", o1_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Reset mid-stream with a word held in ch0.
    send(32'hAAAA_0001, 1'b0);
    in_valid = 1'b0;
    check("mid_o0_valid", 32'(o0_valid), 32'd1);
    check("mid_o0_data", o0_data, 32'hAAAA_0001);
    #2;
    rst_n = 1'b0;
    exp0.delete();
    exp1.delete();
    #1;
    check("async_rst_o0_valid", 32'(o0_valid), 32'd0);
    check("async_rst_o0_data", o0_data, 32'h0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_o0_valid", 32'(o0_valid), 32'd0);
    tick();

    // Basic route to ch1, popped on the following edge.
    o1_ready = 1'b1;
    send(32'h1234_5678, 1'b1);
    in_valid = 1'b0;
    check("route_o1_valid", 32'(o1_valid), 32'd1);
    check("route_o1_data", o1_data, 32'h1234_5678);
    check("route_o0_valid", 32'(o0_valid), 32'd0);
    tick();
    check("route_popped", 32'(o1_valid), 32'd0);
    check("route_hold_data", o1_data, 32'h1234_5678);

    // Fill ch0 and verify back-pressure is per target channel.
    o0_ready = 1'b0;
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    in_data = 32'h3;
    in_sel  = 1'b0;
    #1;
    check("full_ch0_ready", 32'(in_ready), 32'd0);
    in_data = 32'h33;
    in_sel  = 1'b1;
    #1;
    check("full_other_ready", 32'(in_ready), 32'd1);
    exp1.push_back(32'h33);
    tick();
    in_valid = 1'b0;
    check("full_o1_data", o1_data, 32'h33);
    check("full_o0_stable", o0_data, 32'h1);

    // Full with simultaneous pop: push blocked that edge, then accepted.
    o0_ready = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 32'h4;
    #1;
    check("full_pop_ready", 32'(in_ready), 32'd0);
    tick();
    check("full_pop_head", o0_data, 32'h2);
    send(32'h4, 1'b0);
    in_valid = 1'b0;
    check("full_pop_new", o0_data, 32'h4);
    tick();
    check("full_pop_empty", 32'(o0_valid), 32'd0);

    // Streaming alternate channels at one word per cycle.
    o0_ready = 1'b1;
    o1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      logic        s;
      d = 32'h10 + 32'(i);
      s = d[0];
      in_valid = 1'b1;
      in_data  = d;
      in_sel   = s;
      #1;
      check("stream_ready", 32'(in_ready), 32'd1);
      if (s) exp1.push_back(d);
      else   exp0.push_back(d);
      tick();
      check("stream_head", s ? o1_data : o0_data, d);
    end
    in_valid = 1'b0;
    tick();

`ifdef DEMUX_STATS_EN
    apply_reset();
    tick();
    check("stats_rst0", 32'(o0_cnt), 32'd0);
    for (int i = 0; i < 3; i++) send(32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 5; i++) send(32'h200 + 32'(i), 1'b1);
    in_valid = 1'b0;
    check("stats_o0_cnt", 32'(o0_cnt), 32'd3);
    check("stats_o1_cnt", 32'(o1_cnt), 32'd5);
    for (int i = 0; i < 65532; i++) send(32'(i), 1'b0);
    in_valid = 1'b0;
    check("stats_o0_max", 32'(o0_cnt), 32'h0000_FFFF);
    send(32'hCAFE_0000, 1'b0);
    in_valid = 1'b0;
    check("stats_o0_wrap", 32'(o0_cnt), 32'd0);
    check("stats_o1_keep", 32'(o1_cnt), 32'd5);
`endif

    // Drain everything still expected.
    o0_ready = 1'b1;
    o1_ready = 1'b1;
    for (int i = 0; i < 20 && (exp0.size() != 0 || exp1.size() != 0); i++) tick();
    tick();
    check("drain_ch0", 32'(exp0.size()), 32'd0);
    check("drain_ch1", 32'(exp1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux1t2_32_stream.md
Name: demux1t2_32_stream

Overview:
- 32-bit 1-to-2 stream demultiplexer for the datapath: the steering counterpart of the 2:1 word mux.
- Accepts one word per cycle on a valid/ready input channel and routes it by `in_sel` to output channel 0 or 1.
- Each output channel has a 2-entry FIFO buffer, so a stall on one channel never corrupts or reorders the other.
- Sits between a producer stage (e.g. ALU result) and two consumers (e.g. write-back vs. memory path).

Parameters:
- `DW`, 32, data width in bits.
- `DEPTH`, 2, entries per output FIFO. Fixed at 2; other values are unsupported.

Ports:
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `in_valid`  input  1  producer has a word
- `in_ready`  output  1  word accepted this cycle when `in_valid` & `in_ready`
- `in_data`  input  DW  word to route
- `in_sel`  input  1  0 → channel 0, 1 → channel 1; sampled with `in_data`
- `o0_valid`  output  1  channel 0 head entry valid
- `o0_ready`  input  1  channel 0 consumer takes head
- `o0_data`  output  DW  channel 0 head word
- `o1_valid`  output  1  channel 1 head entry valid
- `o1_ready`  input  1  channel 1 consumer takes head
- `o1_data`  output  DW  channel 1 head word
- `o0_cnt`, `o1_cnt`  output  16 each  only present with `DEMUX_STATS_EN`

Behaviour:
- **Clock and reset.** Single clock `clk`. Asynchronous active-low reset `rst_n`.
- **While `rst_n`=0:**
  - FIFO occupancy counts = 0; read/write pointers = 0.
  - `o0_valid` = `o1_valid` = 0.
  - `o0_data` = `o1_data` = 32'h0.
  - `in_ready` = 0.
  - Reset asserted mid-transfer discards all buffered words. No handshake completes on the edge coinciding with reset.
- **Input ready.**
  - `in_ready` = (`rst_n` released) & (count of FIFO[`in_sel`] < 2).
  - Combinational from `in_sel` and registered counts; no combinational path from `o*_ready`.
  - A full target FIFO back-pressures the input even if the other FIFO has space.
- **Push.** On a rising edge with `in_valid` & `in_ready`: write `in_data` at FIFO[`in_sel`].wptr, increment wptr (mod 2) and count.
- **Pop.** On a rising edge with `oN_valid` & `oN_ready`: increment FIFO[N].rptr (mod 2) and decrement count.
- **Simultaneous push and pop on the same channel.**
  - Count unchanged; both pointers advance.
  - Allowed at count 1.
  - At count 2, push is blocked (`in_ready` = 0) even if a pop occurs the same cycle. There is no fall-through when full.
- **Outputs.**
  - `oN_valid` = (count_N != 0).
  - `oN_data` = mem_N[rptr_N].
  - When `oN_valid` = 0, `oN_data` is held at the last value (32'h0 after reset); consumers must ignore it.
- **Latency and ordering.**
  - A word accepted at edge k is visible on `oN_valid`/`oN_data` after edge k (1-cycle latency).
  - Throughput is 1 word/cycle per channel when the consumer is ready.
  - Per-channel order is preserved. There is no ordering guarantee between channels.
- **Stability.** While `oN_valid` = 1 and `oN_ready` = 0, `oN_data` stays stable.
- **Pointer wrap.** Pointers are 1 bit wide; wrap from 1 to 0 is natural. The count is 2 bits, range 0..2; a count of 3 is illegal and must never occur.
- **Unselected channel.** `in_sel` changing while `in_valid` = 1 and `in_ready` = 0 is legal. Readiness re-evaluates against the new target.

Optional Feature:
- **Macro `DEMUX_STATS_EN`, when defined:**
  - Adds outputs `o0_cnt` and `o1_cnt` (16 bits each).
  - Each counts words accepted into its channel (push events).
  - Reset to 0 by `rst_n`; wraps 16'hFFFF → 16'h0000.
  - Increments on the same edge as the push.
- **When undefined:** the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- **Reset mid-stream.** Push 32'hAAAA0001 to ch0, hold `o0_ready`=0, assert `rst_n`=0 asynchronously between edges → `o0_valid`=0 and `o0_data`=0 immediately; after release, `in_ready`=1 and ch0 is empty.
- **Basic route.** Push 32'h12345678 with `in_sel`=1, `o1_ready`=1 → next cycle `o1_valid`=1 with 32'h12345678; `o0_valid` stays 0; word popped the following edge.
- **Fill and back-pressure.** `o0_ready`=0; push 32'h1, then 32'h2 to ch0 → third attempt with `in_sel`=0 sees `in_ready`=0; with `in_sel`=1 in the same cycle, `in_ready`=1 and the word lands in ch1.
- **Full with simultaneous pop.** ch0 count 2, `o0_ready`=1, `in_valid`=1, `in_sel`=0 → no push that edge (`in_ready`=0), ch0 pops 32'h1; next cycle a push succeeds and the output order is 32'h2, then the new word.
- **Streaming at count 1.** Alternate `in_sel` 0/1 every cycle for 8 words 32'h10..32'h17, both readies = 1 → ch0 emits 10, 12, 14, 16 and ch1 emits 11, 13, 15, 17, one per cycle, with no `in_ready` drop.
- **Stats (`DEMUX_STATS_EN`).** Push 3 words to ch0 and 5 to ch1 → `o0_cnt`=3, `o1_cnt`=5. Preload 16'hFFFF by pushing 65535 words, then push one more → `o0_cnt`=0.
